// File: rtl/line_pkg.sv
// Shared definitions for the pulse-width link (transmitter and receiver).
package line_pkg;

    // Clock cycles per width unit; matches the receiver's tick divider.
    localparam int LINE_TICK_DIV  = 500;
    // Width of the value field carried on the line.
    localparam int LINE_CNT_W     = 8;
    // Low time after each pulse, in ticks.
    localparam int LINE_GAP_TICKS = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } line_state_e;

endpackage : line_pkg

// File: rtl/tick_prescaler.sv
// Free-running divide-by-TICK_DIV counter producing a one-cycle tick.
// While clear is high the counter is held at zero, so the first tick after
// clear drops arrives exactly TICK_DIV cycles later.
module tick_prescaler
    import line_pkg::*;
#(
    parameter int TICK_DIV = LINE_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] cnt_q;
    logic [PRE_W-1:0] cnt_d;

    // Next count: hold at zero on clear, wrap after the last count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == PRE_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The tick must not depend on clear: clear is derived from the
    // consumer's state, and the consumer's next state depends on tick.
    assign tick = (cnt_q == PRE_LAST);

endmodule : tick_prescaler

// File: rtl/pulse_width_gen.sv
// Pulse-width link transmitter: drives pulse_out high for width x TICK_DIV
// cycles, then low for GAP_TICKS x TICK_DIV cycles, optionally repeating.
module pulse_width_gen
    import line_pkg::*;
#(
    parameter int TICK_DIV  = LINE_TICK_DIV,
    parameter int CNT_W     = LINE_CNT_W,
    parameter int GAP_TICKS = LINE_GAP_TICKS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] width_in,
    input  logic             start,
    input  logic             repeat_en,
    output logic             ready,
    output logic             pulse_out,
    output logic             done,
    output logic [CNT_W-1:0] active_width
);

    // Tick counts are compared one bit wider so the increment never wraps.
    localparam logic [CNT_W:0] GAP_END = (CNT_W + 1)'(GAP_TICKS);

    line_state_e      state_q, state_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [CNT_W-1:0] active_width_q, active_width_d;
    logic             pulse_out_q, pulse_out_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;

    logic             tick;
    logic             pre_clear;
    logic [CNT_W:0]   tick_nxt;

    // Prescaler runs only while a pulse or gap is in progress.
    assign pre_clear = (state_q == ST_IDLE);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (pre_clear),
        .tick  (tick)
    );

    assign tick_nxt = {1'b0, tick_cnt_q} + 1'b1;

    // Next-state logic and registered-output values.
    always_comb begin
        state_d        = state_q;
        tick_cnt_d     = tick_cnt_q;
        active_width_d = active_width_q;
        done_d         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tick_cnt_d = '0;
                // A zero width would be an empty pulse; it is not a request.
                if (start && (width_in != '0)) begin
                    state_d        = ST_HIGH;
                    active_width_d = width_in;
                end
            end

            ST_HIGH: begin
                if (tick) begin
                    if (tick_nxt == {1'b0, active_width_q}) begin
                        state_d    = ST_GAP;
                        tick_cnt_d = '0;
                    end else begin
                        tick_cnt_d = tick_nxt[CNT_W-1:0];
                    end
                end
            end

            ST_GAP: begin
                if (tick) begin
                    if (tick_nxt == GAP_END) begin
                        tick_cnt_d = '0;
                        if (repeat_en) begin
                            state_d = ST_HIGH;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_nxt[CNT_W-1:0];
                    end
                end
            end

            default: begin
                state_d    = ST_IDLE;
                tick_cnt_d = '0;
            end
        endcase

        // Outputs follow the state being entered so they appear registered
        // in the same cycle as the state itself.
        pulse_out_d = (state_d == ST_HIGH);
        ready_d     = (state_d == ST_IDLE);
    end

    // State, counters and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            tick_cnt_q     <= '0;
            active_width_q <= '0;
            pulse_out_q    <= 1'b0;
            ready_q        <= 1'b1;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            tick_cnt_q     <= tick_cnt_d;
            active_width_q <= active_width_d;
            pulse_out_q    <= pulse_out_d;
            ready_q        <= ready_d;
            done_q         <= done_d;
        end
    end

    assign ready        = ready_q;
    assign pulse_out    = pulse_out_q;
    assign done         = done_q;
    assign active_width = active_width_q;

endmodule : pulse_width_gen

// File: tb/tb_pulse_width_gen.sv
// Directed bench for pulse_width_gen with TICK_DIV=4, GAP_TICKS=2.
module tb_pulse_width_gen;

    localparam int TD = 4;
    localparam int GT = 2;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] width_in;
    logic          start;
    logic          repeat_en;
    logic          ready;
    logic          pulse_out;
    logic          done;
    logic [CW-1:0] active_width;

    int errors = 0;
    int checks = 0;
    int seen_done;
    int seen_ready;
    int n;

    pulse_width_gen #(
        .TICK_DIV  (TD),
        .CNT_W     (CW),
        .GAP_TICKS (GT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .width_in     (width_in),
        .start        (start),
        .repeat_en    (repeat_en),
        .ready        (ready),
        .pulse_out    (pulse_out),
        .done         (done),
        .active_width (active_width)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Count consecutive cycles with pulse_out at lvl, bounded by limit.
    task automatic count_level(input logic lvl, input int limit, output int cnt);
        cnt = 0;
        while ((pulse_out === lvl) && (cnt < limit)) begin
            if (done === 1'b1)  seen_done++;
            if (ready === 1'b1) seen_ready++;
            cnt++;
            step();
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        repeat_en = 1'b0;
        width_in  = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_pulse", 32'(pulse_out), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_active", 32'(active_width), 32'd0);

        // Test 1: width 3 -> 12 high, 8 low, done in cycle 21
        width_in = 8'd3;
        start    = 1'b1;
        step();
        start    = 1'b0;
        check("t1_pulse_c1", 32'(pulse_out), 32'd1);
        check("t1_ready_c1", 32'(ready), 32'd0);
        check("t1_active", 32'(active_width), 32'd3);
        seen_done  = 0;
        seen_ready = 0;
        count_level(1'b1, 2000, n);
        check("t1_high_len", 32'(n), 32'd12);
        count_level(1'b0, GT * TD, n);
        check("t1_gap_len", 32'(n), 32'd8);
        check("t1_no_early_done", 32'(seen_done), 32'd0);
        check("t1_ready_low_busy", 32'(seen_ready), 32'd0);
        check("t1_done", 32'(done), 32'd1);
        check("t1_ready_done", 32'(ready), 32'd1);
        step();
        check("t1_done_one_cycle", 32'(done), 32'd0);
        check("t1_ready_idle", 32'(ready), 32'd1);

        // Test 2: zero width is ignored
        width_in = 8'd0;
        start    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_pulse", 32'(pulse_out), 32'd0);
            check("t2_ready", 32'(ready), 32'd1);
            check("t2_done", 32'(done), 32'd0);
        end
        start = 1'b0;
        check("t2_active_hold", 32'(active_width), 32'd3);

        // Test 3: maximum width, no wrap
        width_in = 8'd255;
        start    = 1'b1;
        step();
        start    = 1'b0;
        check("t3_active", 32'(active_width), 32'd255);
        seen_done = 0;
        count_level(1'b1, 1100, n);
        check("t3_high_len", 32'(n), 32'd1020);
        count_level(1'b0, GT * TD, n);
        check("t3_gap_len", 32'(n), 32'd8);
        check("t3_no_early_done", 32'(seen_done), 32'd0);
        check("t3_done", 32'(done), 32'd1);
        step();

        // Test 4: repeat three bursts of width 2
        repeat_en = 1'b1;
        width_in  = 8'd2;
        start     = 1'b1;
        step();
        start     = 1'b0;
        seen_done  = 0;
        seen_ready = 0;
        for (int b = 0; b < 3; b++) begin
            if (b == 2) repeat_en = 1'b0;
            count_level(1'b1, 100, n);
            check($sformatf("t4_high_len_b%0d", b), 32'(n), 32'd8);
            count_level(1'b0, GT * TD, n);
            check($sformatf("t4_gap_len_b%0d", b), 32'(n), 32'd8);
        end
        check("t4_no_early_done", 32'(seen_done), 32'd0);
        check("t4_ready_low", 32'(seen_ready), 32'd0);
        check("t4_done", 32'(done), 32'd1);
        check("t4_active", 32'(active_width), 32'd2);
        step();

        // Test 5: start while busy ignored; start in done cycle accepted
        width_in = 8'd2;
        start    = 1'b1;
        step();
        width_in = 8'd5;
        count_level(1'b1, 100, n);
        check("t5_high_len", 32'(n), 32'd8);
        check("t5_active_kept", 32'(active_width), 32'd2);
        start = 1'b0;
        count_level(1'b0, GT * TD, n);
        check("t5_gap_len", 32'(n), 32'd8);
        check("t5_done", 32'(done), 32'd1);
        width_in = 8'd3;
        start    = 1'b1;
        step();
        start    = 1'b0;
        check("t5_b2b_pulse", 32'(pulse_out), 32'd1);
        check("t5_b2b_active", 32'(active_width), 32'd3);
        count_level(1'b1, 100, n);
        check("t5_b2b_high_len", 32'(n), 32'd12);
        count_level(1'b0, GT * TD, n);
        check("t5_b2b_gap_len", 32'(n), 32'd8);
        check("t5_b2b_done", 32'(done), 32'd1);
        step();

        // Test 6: reset mid-pulse, then a fresh width-1 burst
        width_in = 8'd4;
        start    = 1'b1;
        step();
        start    = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("t6_pulse_before_rst", 32'(pulse_out), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rst_pulse", 32'(pulse_out), 32'd0);
        check("t6_rst_ready", 32'(ready), 32'd1);
        check("t6_rst_active", 32'(active_width), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        width_in = 8'd1;
        start    = 1'b1;
        step();
        start    = 1'b0;
        count_level(1'b1, 100, n);
        check("t6_high_len", 32'(n), 32'd4);
        count_level(1'b0, GT * TD, n);
        check("t6_gap_len", 32'(n), 32'd8);
        check("t6_done", 32'(done), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pulse_width_gen

// File: doc/pulse_width_gen.md
Name: pulse_width_gen

Overview:
- Transmitter end of the pulse-width link.
- Takes an 8-bit value and drives a single output high for exactly value × TICK_DIV clock cycles, then drives it low for a fixed gap.
- The gap lets the line's width counter latch the value.
- Used to stimulate the width-measurement path in-system and on the bench, and to send small counts between boards over one wire.

Parameters:
- TICK_DIV, 500, clock cycles per width unit; must be ≥ 2; matches the receiver's divide-by-500 tick.
- CNT_W, 8, width of the value field.
- GAP_TICKS, 2, low time after each pulse, in ticks; must be ≥ 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- width_in  input  CNT_W  pulse width in ticks; sampled on an accepted start.
- start  input  1  request to send width_in; accepted only when ready=1.
- repeat_en  input  1  level; when 1 at gap end, the same width is re-sent with no idle cycle.
- ready  output  1  1 only in IDLE.
- pulse_out  output  1  the line; registered.
- done  output  1  one-cycle strobe when a burst completes.
- active_width  output  CNT_W  latched width currently being sent; holds after completion.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. All outputs are registered.
- Reset values (1 cycle after rst sampled high): state=IDLE, pulse_out=0, ready=1, done=0, active_width=0, prescaler=0, tick count=0.
- Reset mid-operation: pulse_out drops to 0 on the next edge. Reset overrides start.
- States: IDLE, HIGH, GAP.
- IDLE:
  - start=1 with width_in≠0 accepts the request.
  - On the next edge: state=HIGH, pulse_out=1, ready=0, active_width=width_in, prescaler and tick count cleared.
  - start=1 with width_in=0 is ignored. State stays IDLE, no done, pulse_out stays 0.
- HIGH:
  - The prescaler counts 0..TICK_DIV-1 and wraps. Each wrap increments the tick count.
  - When the tick count reaches active_width, state goes to GAP on that edge, with pulse_out=0 and counters cleared.
  - pulse_out is therefore high for exactly active_width × TICK_DIV cycles.
- GAP:
  - Same counting, to GAP_TICKS. pulse_out is low for exactly GAP_TICKS × TICK_DIV cycles.
  - At gap end with repeat_en=1: state=HIGH, pulse_out=1, same active_width. No done, ready stays 0.
  - At gap end with repeat_en=0: state=IDLE, ready=1, done=1 for one cycle.
- Latency: start accepted at edge N gives pulse_out=1 from cycle N+1.
- Handshake:
  - start while ready=0 is ignored; no queueing.
  - width_in changes after acceptance have no effect.
  - start in the same cycle done=1 is accepted (ready=1 then), giving back-to-back bursts separated by the gap only.
- Width rules:
  - Tick count is CNT_W bits and never wraps; the maximum value 255 gives 255×TICK_DIV cycles.
  - Prescaler width is clog2(TICK_DIV).
  - All compares are unsigned.

Decomposition:
- Shared package line_pkg:
  - state encoding (IDLE/HIGH/GAP);
  - default TICK_DIV=500, shared with the width counter;
  - CNT_W=8;
  - GAP_TICKS default.
- One natural sub-module, tick_prescaler:
  - inputs: clk, rst, clear;
  - output: one-cycle tick every TICK_DIV cycles;
  - reused by the receiver rewrite.

Test Plan (TICK_DIV=4, GAP_TICKS=2):
1. Reset, then start with width_in=3 at edge 0 → pulse_out=1 cycles 1–12, 0 from cycle 13; done=1 and ready=1 in cycle 21 only; active_width=3.
2. width_in=0 with start → no state change, pulse_out stays 0, no done, ready stays 1.
3. width_in=255, repeat_en=0 → high exactly 1020 cycles, then low 8 cycles, then done; no wrap to a short pulse.
4. width_in=2, repeat_en=1 for three bursts, then dropped → three 8-cycle highs separated by 8-cycle lows; done only after the last burst; ready=0 throughout.
5. Assert start with width 5 during HIGH of a width-2 burst; change width_in mid-burst → ignored, high stays 8 cycles; new start in the done cycle is accepted with a new width.
6. rst asserted in cycle 6 of HIGH → pulse_out=0, ready=1 next cycle; a fresh width-1 start after reset gives a 4-cycle high.
